// File: rtl/uart_rx_buffer_ctrl_if.sv
// uart_rx_buffer_ctrl_if: receiver-side and consumer-side signals of the UART RX buffer.
interface uart_rx_buffer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int OVR_W = 8
);
    logic                   rx_ready;
    logic [WIDTH-1:0]       rx_data;
    logic                   rx_can_receive;
    logic                   clear;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [$clog2(DEPTH):0] level;
    logic [OVR_W-1:0]       overrun_count;
    logic                   idle_flag;
    modport master (
        output rx_ready, rx_data, clear, out_ready,
        input  rx_can_receive, out_valid, out_data, level, overrun_count, idle_flag
    );
    modport slave (
        input  rx_ready, rx_data, clear, out_ready,
        output rx_can_receive, out_valid, out_data, level, overrun_count, idle_flag
    );
endinterface

// File: rtl/uart_rx_buffer_ctrl.sv
// uart_rx_buffer_ctrl: flow-controlled show-ahead FIFO behind a UART receiver, with
// saturating overrun count and an idle-with-data flag used as a frame delimiter.
module uart_rx_buffer_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int OVR_W         = 8
) (
    input logic                     clock_i,
    input logic                     resetn_i,
    uart_rx_buffer_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             idle_q, idle_d;
    logic             push, pop, drop, wr_en, quiet;

    always_comb begin
        push     = bus.rx_ready && !bus.clear;
        pop      = (level_q != '0) && bus.out_ready && !bus.clear;
        drop     = push && !pop && (level_q == LW'(DEPTH));
        wr_en    = push && !drop;
        wr_ptr_d = bus.clear ? '0 : wr_ptr_q + AW'(wr_en);
        rd_ptr_d = bus.clear ? '0 : rd_ptr_q + AW'(pop);
        level_d  = bus.clear ? '0 : level_q + LW'(wr_en) - LW'(pop);
        ovr_d    = bus.clear ? '0 : ovr_q + OVR_W'(drop && (ovr_q != '1));
        // Any push, a drained FIFO or a flush restarts the idle measurement.
        quiet    = bus.clear || push || (level_d == '0);
        cnt_d    = quiet ? '0 : cnt_q + CW'(cnt_q < CW'(TIMEOUT_TICKS));
        idle_d   = quiet ? 1'b0 : (idle_q || (cnt_q == CW'(TIMEOUT_TICKS)));
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= '0;
            cnt_q    <= '0;
            idle_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    // One slot stays reserved for a word already in flight when permission drops.
    assign bus.rx_can_receive = (level_q < LW'(DEPTH - 1)) && !bus.clear;
    assign bus.out_valid      = (level_q != '0);
    assign bus.out_data       = mem_q[rd_ptr_q];
    assign bus.level          = level_q;
    assign bus.overrun_count  = ovr_q;
    assign bus.idle_flag      = idle_q;
endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// tb_uart_rx_buffer_ctrl: directed scenarios plus random traffic checked every cycle
// against a queue-based reference model of the buffer.
module tb_uart_rx_buffer_ctrl;
    localparam int DEPTH = 16;
    localparam int TMO   = 10;
    localparam int OVR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mq[$];
    int m_ovr, m_cnt;
    bit m_flag;

    uart_rx_buffer_ctrl_if #(.WIDTH(8), .DEPTH(DEPTH), .OVR_W(OVR_W)) bus ();
    uart_rx_buffer_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .TIMEOUT_TICKS(TMO), .OVR_W(OVR_W)) dut (
        .clock_i (clk),
        .resetn_i(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 0;
        m_cnt = 0;
        m_flag = 0;
    endtask

    task automatic idle_inputs();
        bus.rx_ready = 0;
        bus.rx_data = 0;
        bus.out_ready = 0;
        bus.clear = 0;
    endtask

    task automatic model_check();
        chk("level", 32'(bus.level), 32'(mq.size()));
        chk("valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("data", 32'(bus.out_data), 32'(mq[0]));
        chk("ovr", 32'(bus.overrun_count), 32'(m_ovr));
        chk("idle", 32'(bus.idle_flag), 32'(m_flag));
        chk("can_rx", 32'(bus.rx_can_receive), 32'((mq.size() < DEPTH - 1) && !bus.clear));
    endtask

    task automatic model_edge(input bit rr, input logic [7:0] d, input bit ordy, input bit clr);
        bit push, pop;
        int old;
        push = rr && !clr;
        pop = (mq.size() != 0) && ordy && !clr;
        if (clr) begin
            model_reset();
            return;
        end
        old = mq.size();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (old == DEPTH && !pop) m_ovr = (m_ovr == (1 << OVR_W) - 1) ? m_ovr : m_ovr + 1;
            else mq.push_back(d);
        end
        if (push || mq.size() == 0) begin
            m_flag = 0;
            m_cnt = 0;
        end else begin
            if (m_cnt == TMO) m_flag = 1;
            if (m_cnt < TMO) m_cnt++;
        end
    endtask

    task automatic step(input bit rr, input logic [7:0] d, input bit ordy, input bit clr);
        bus.rx_ready = rr;
        bus.rx_data = d;
        bus.out_ready = ordy;
        bus.clear = clr;
        #1;
        model_check();
        @(posedge clk);
        #1;
        idle_inputs();
        model_edge(rr, d, ordy, clr);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) step(0, 0, 1, 0);
        chk("drained", 32'(bus.level), 0);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ovr", 32'(bus.overrun_count), 0);
        chk("rst_idle", 32'(bus.idle_flag), 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_can_rx", 32'(bus.rx_can_receive), 1);

        step(1, 8'hA5, 0, 0);
        chk("first_data", 32'(bus.out_data), 32'h A5);
        chk("first_level", 32'(bus.level), 1);
        chk("first_can_rx", 32'(bus.rx_can_receive), 1);
        step(0, 0, 0, 1);

        for (int i = 0; i < 15; i++) step(1, 8'(i), 0, 0);
        chk("high_can_rx", 32'(bus.rx_can_receive), 0);
        step(1, 8'h0F, 0, 0);
        chk("full_level", 32'(bus.level), 16);
        step(1, 8'h10, 0, 0);
        chk("drop_ovr", 32'(bus.overrun_count), 1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(bus.out_data), 32'(i));
            step(0, 0, 1, 0);
        end
        chk("drain_empty", 32'(bus.out_valid), 0);

        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        chk("full_pp_level", 32'(bus.level), 16);
        chk("full_pp_head", 32'(bus.out_data), 32'h41);
        chk("full_pp_ovr", 32'(bus.overrun_count), 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
        chk("full_pp_last", 32'(bus.out_data), 32'h77);
        drain();

        step(0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(i * 7 + 3), 1, 0);
            chk("wrap_level", 32'(bus.level <= 1), 1);
        end
        chk("wrap_ovr", 32'(bus.overrun_count), 0);
        drain();

        step(0, 0, 0, 1);
        step(1, 8'h5A, 0, 0);
        repeat (10) step(0, 0, 0, 0);
        chk("idle_pre", 32'(bus.idle_flag), 0);
        step(0, 0, 0, 0);
        chk("idle_at", 32'(bus.idle_flag), 1);
        step(1, 8'h5B, 0, 0);
        chk("idle_push_clr", 32'(bus.idle_flag), 0);
        repeat (12) step(0, 0, 0, 0);
        chk("idle_again", 32'(bus.idle_flag), 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("idle_empty_clr", 32'(bus.idle_flag), 0);

        step(0, 0, 0, 1);
        for (int i = 0; i < 19; i++) step(1, 8'(i), 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
        chk("pre_clr_ovr", 32'(bus.overrun_count), 3);
        chk("pre_clr_level", 32'(bus.level), 5);
        step(1, 8'h33, 1, 1);
        chk("clr_level", 32'(bus.level), 0);
        chk("clr_valid", 32'(bus.out_valid), 0);
        chk("clr_ovr", 32'(bus.overrun_count), 0);
        chk("clr_idle", 32'(bus.idle_flag), 0);

        for (int ph = 0; ph < 12; ph++) begin
            int pr, po;
            pr = $urandom_range(10, 90);
            po = $urandom_range(0, 100);
            for (int i = 0; i < 250; i++)
                step($urandom_range(99) < pr, 8'($urandom), $urandom_range(99) < po,
                     $urandom_range(199) == 0);
        end

        for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_rst_level", 32'(bus.level), 0);
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        step(1, 8'hC3, 0, 0);
        step(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
